// File: rtl/float_dot_seq_pkg.sv
// Shared state encoding and derived-width helpers for the dot-product sequencer.
package float_dot_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int exp_out(input int exp_in);
    return exp_in + 1;
  endfunction

  function automatic int frac_out(input int frac_in);
    return 2 * frac_in + 1;
  endfunction

  function automatic int acc_frac(input int exp_in, input int frac_in);
    return frac_out(frac_in) + 2 ** (exp_out(exp_in) - 1) - 2;
  endfunction

  function automatic int acc_non_frac(input int exp_in, input int extra_bits);
    return extra_bits + 1 + 2 ** (exp_out(exp_in) - 1);
  endfunction

  function automatic int acc_w(input int exp_in, input int frac_in, input int extra_bits);
    return acc_frac(exp_in, frac_in) + acc_non_frac(exp_in, extra_bits);
  endfunction

endpackage

// File: rtl/float_dot_product_sequencer_if.sv
// Command, operand and result handshake bundle of the dot-product sequencer.
interface float_dot_product_sequencer_if #(
  parameter int LEN_WIDTH = 16,
  parameter int OP_W      = 6,
  parameter int ACC_W     = 28
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [LEN_WIDTH-1:0] cmd_len;
  logic                 cmd_clear;
  logic                 in_valid;
  logic                 in_ready;
  logic [OP_W-1:0]      in_a;
  logic [OP_W-1:0]      in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_W-1:0]     out_acc;

  modport master (
    output cmd_valid, cmd_len, cmd_clear, in_valid, in_a, in_b, out_ready,
    input  cmd_ready, in_ready, out_valid, out_acc
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_clear, in_valid, in_a, in_b, out_ready,
    output cmd_ready, in_ready, out_valid, out_acc
  );
endinterface

// File: rtl/float_dot_product_sequencer_fma.sv
// Exact float multiply added into a Kulisch fixed-point accumulator.
// Every exponent code is finite; exponent 0 encodes denormals.
module float_dot_product_sequencer_fma #(
  parameter int EXP_IN             = 3,
  parameter int FRAC_IN            = 2,
  parameter int TRAILING_BITS      = 2,
  parameter int OVERFLOW_DETECTION = 0,
  parameter int ACC_FRAC           = 11,
  parameter int ACC_W              = 28
) (
  input  logic [EXP_IN+FRAC_IN:0] a_i,
  input  logic [EXP_IN+FRAC_IN:0] b_i,
  input  logic [ACC_W-1:0]        acc_i,
  output logic [ACC_W-1:0]        acc_o
);
  localparam int SIG_W     = FRAC_IN + 1;
  localparam int BIAS      = 2 ** (EXP_IN - 1) - 1;
  localparam int SHIFT_OFS = ACC_FRAC - 2 * (BIAS + FRAC_IN);
  localparam int SH_W      = EXP_IN + 2;
  localparam int SIGN_BIT  = EXP_IN + FRAC_IN;

  logic [SIG_W-1:0]   sig_a_s, sig_b_s;
  logic [EXP_IN-1:0]  exp_a_s, exp_b_s, eff_a_s, eff_b_s;
  logic [2*SIG_W-1:0] prod_s;
  logic [SH_W-1:0]    shift_s;
  logic [ACC_W-1:0]   mag_s, term_s;

  if (TRAILING_BITS < 0 || OVERFLOW_DETECTION != 0 || SHIFT_OFS < 0) begin : g_param_check
    $error("unsupported FloatMultiplyAdd configuration");
  end

  // Product LSB weight is 2^(2*(1-BIAS-FRAC_IN)), so the shift places it exactly on the accumulator grid.
  always_comb begin
    exp_a_s = a_i[SIGN_BIT-1:FRAC_IN];
    exp_b_s = b_i[SIGN_BIT-1:FRAC_IN];
    sig_a_s = {|exp_a_s, a_i[FRAC_IN-1:0]};
    sig_b_s = {|exp_b_s, b_i[FRAC_IN-1:0]};
    eff_a_s = (|exp_a_s) ? exp_a_s : EXP_IN'(1);
    eff_b_s = (|exp_b_s) ? exp_b_s : EXP_IN'(1);
    prod_s  = {{SIG_W{1'b0}}, sig_a_s} * {{SIG_W{1'b0}}, sig_b_s};
    shift_s = SH_W'(eff_a_s) + SH_W'(eff_b_s) + SH_W'(SHIFT_OFS);
    mag_s   = {{(ACC_W-2*SIG_W){1'b0}}, prod_s} << shift_s;
    term_s  = (a_i[SIGN_BIT] ^ b_i[SIGN_BIT]) ? (~mag_s + ACC_W'(1)) : mag_s;
    acc_o   = acc_i + term_s;
  end
endmodule

// File: rtl/float_dot_product_sequencer.sv
// Runs N operand pairs through one multiply-add, keeping the Kulisch sum in a
// register, and hands the final sum out on a valid/ready result port.
module float_dot_product_sequencer
  import float_dot_seq_pkg::*;
#(
  parameter int EXP_IN        = 3,
  parameter int FRAC_IN       = 2,
  parameter int TRAILING_BITS = 2,
  parameter int ACC_EXTRA_BIT = 8,
  parameter int LEN_WIDTH     = 16
) (
  input logic                          clock,
  input logic                          reset,
  float_dot_product_sequencer_if.slave bus
);
  localparam int ACC_FRAC = acc_frac(EXP_IN, FRAC_IN);
  localparam int ACC_W    = acc_w(EXP_IN, FRAC_IN, ACC_EXTRA_BIT);

  state_e               state_q;
  logic [LEN_WIDTH-1:0] count_q;
  logic [ACC_W-1:0]     acc_q, acc_d, out_acc_q;
  logic                 cmd_ready_q, in_ready_q, out_valid_q;

  float_dot_product_sequencer_fma #(
    .EXP_IN             (EXP_IN),
    .FRAC_IN            (FRAC_IN),
    .TRAILING_BITS      (TRAILING_BITS),
    .OVERFLOW_DETECTION (0),
    .ACC_FRAC           (ACC_FRAC),
    .ACC_W              (ACC_W)
  ) u_fma (
    .a_i   (bus.in_a),
    .b_i   (bus.in_b),
    .acc_i (acc_q),
    .acc_o (acc_d)
  );

  // Sequencer FSM with length counter, sum register and registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      out_acc_q   <= '0;
      cmd_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            count_q     <= bus.cmd_len;
            cmd_ready_q <= 1'b0;
            if (bus.cmd_clear) begin
              acc_q <= '0;
            end
            if (bus.cmd_len != '0) begin
              state_q    <= RUN;
              in_ready_q <= 1'b1;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_acc_q   <= bus.cmd_clear ? '0 : acc_q;
            end
          end
        end
        RUN: begin
          if (bus.in_valid) begin
            acc_q   <= acc_d;
            count_q <= count_q - LEN_WIDTH'(1);
            if (count_q == LEN_WIDTH'(1)) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_acc_q   <= acc_d;
            end
          end
        end
        DONE: begin
          // The sum stays in acc_q so a following cmd_clear=0 command can chain onto it.
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
endmodule
